store_write_buffer: RTL and testbench

- Responder end of the ROB-to-DataCache store-commit interface; receives committed stores (address, byte mask, lane-aligned data) from the ROB.
- Accepts each store into a small in-order FIFO and drains entries one at a time to the data memory over a req/ack handshake.
- `dcache_write_valid` tells the ROB a store can be accepted this cycle, so ROB commit stalls only while the buffer is full.

---
 rtl/store_write_buffer_pkg.sv | 26 ++
 rtl/store_fifo_ram.sv | 44 ++++
 rtl/store_write_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_store_write_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/store_write_buffer_pkg.sv
// Shared definitions for the store write buffer: default widths, word-address
// mask, the {addr, mask, data} entry layout and the drain FSM state type.
package store_write_buffer_pkg;

    localparam int Addr_Width = 32;
    localparam int Data_Width = 32;
    localparam int Mask_Width = 4;

    // Stores are word aligned on the way into the buffer.
    localparam logic [Addr_Width-1:0] Addr_Mask = 32'hFFFF_FFFC;

    // Entry layout, LSB first: data, then byte mask, then word address.
    localparam int Entry_Data_Lo = 0;
    localparam int Entry_Data_Hi = Data_Width - 1;
    localparam int Entry_Mask_Lo = Data_Width;
    localparam int Entry_Mask_Hi = Data_Width + Mask_Width - 1;
    localparam int Entry_Addr_Lo = Data_Width + Mask_Width;
    localparam int Entry_Addr_Hi = Data_Width + Mask_Width + Addr_Width - 1;
    localparam int Entry_Width   = Addr_Width + Mask_Width + Data_Width;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } swb_state_t;

endpackage

// File: rtl/store_fifo_ram.sv
// Register array holding the queued stores. One write port, one combinational
// read port for the entry about to be presented to memory. With STORE_FWD_EN
// defined, every slot is also exported for the store-to-load address compare.
module store_fifo_ram
    import store_write_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2,
    parameter int ENTRY_W   = Entry_Width
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH-1:0] wr_ptr,
    input  logic [ENTRY_W-1:0]   wr_entry,
    input  logic [PTR_WIDTH-1:0] rd_ptr,
    output logic [ENTRY_W-1:0]   rd_entry
`ifdef STORE_FWD_EN
    ,
    output logic [ENTRY_W-1:0]   all_entries [DEPTH]
`endif
);

    logic [ENTRY_W-1:0] mem_array [DEPTH];

    // Entry storage; contents are only meaningful where the count says so,
    // so the array needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = mem_array[rd_ptr];

`ifdef STORE_FWD_EN
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_all
            assign all_entries[gi] = mem_array[gi];
        end
    endgenerate
`endif

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: accepts committed stores from the ROB into an in-order
// FIFO and drains them one at a time to data memory over mem_req/mem_ack.
// The head entry is counted until acknowledged, so buf_count includes the
// store in flight. Optional feature macro: STORE_FWD_EN adds a combinational
// store-to-load forwarding port that searches every valid entry.
module store_write_buffer
    import store_write_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = Addr_Width,
    parameter int DATA_WIDTH = Data_Width,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dcache_write,
    input  logic [Mask_Width-1:0] dcache_mask,
    input  logic [ADDR_WIDTH-1:0] dcache_addr,
    input  logic [DATA_WIDTH-1:0] dcache_data,
    output logic                  dcache_write_valid,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [Mask_Width-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    output logic                  buf_empty,
    output logic [PTR_WIDTH:0]    buf_count
`ifdef STORE_FWD_EN
    ,
    input  logic                  fwd_check,
    input  logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic                  fwd_hit,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic [Mask_Width-1:0] fwd_mask
`endif
);

    localparam int ENTRY_W = ADDR_WIDTH + Mask_Width + DATA_WIDTH;
    localparam int DATA_LO = 0;
    localparam int MASK_LO = DATA_WIDTH;
    localparam int ADDR_LO = DATA_WIDTH + Mask_Width;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
    localparam logic [PTR_WIDTH-1:0]  PTR_ONE   = 1;
    localparam logic [PTR_WIDTH:0]    CNT_ONE   = 1;
    localparam logic [PTR_WIDTH:0]    CNT_FULL  = (PTR_WIDTH + 1)'(DEPTH);

    swb_state_t            state_reg, state_next;
    logic [PTR_WIDTH:0]    count_reg, count_next;
    logic [PTR_WIDTH-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic                  mem_req_reg, mem_req_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [Mask_Width-1:0] mem_wmask_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic [PTR_WIDTH-1:0]  load_ptr;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    load_entry;

    assign full               = (count_reg == CNT_FULL);
    assign dcache_write_valid = !full;
    // Zero-mask stores are acknowledged to the ROB but never occupy a slot.
    assign push     = dcache_write && !full && (dcache_mask != '0);
    assign wr_entry = {dcache_addr & WORD_MASK, dcache_mask, dcache_data};

`ifdef STORE_FWD_EN
    logic [ENTRY_W-1:0] all_entries [DEPTH];
`endif

    store_fifo_ram #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .ENTRY_W   (ENTRY_W)
    ) u_ram (
        .clk         (clk),
        .wr_en       (push),
        .wr_ptr      (wr_ptr_reg),
        .wr_entry    (wr_entry),
        .rd_ptr      (load_ptr),
        .rd_entry    (load_entry)
`ifdef STORE_FWD_EN
        ,
        .all_entries (all_entries)
`endif
    );

    // Drain FSM: present the head, wait for ack, chain straight into the next
    // entry when one is already queued so streaming has no bubble.
    always_comb begin
        state_next   = state_reg;
        mem_req_next = mem_req_reg;
        load         = 1'b0;
        load_ptr     = rd_ptr_reg;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    load         = 1'b1;
                    mem_req_next = 1'b1;
                    state_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    pop = 1'b1;
                    if (count_reg != CNT_ONE) begin
                        load     = 1'b1;
                        load_ptr = rd_ptr_reg + PTR_ONE;
                    end else begin
                        mem_req_next = 1'b0;
                        state_next   = ST_IDLE;
                    end
                end
            end
            default: begin
                mem_req_next = 1'b0;
                state_next   = ST_IDLE;
            end
        endcase
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (!push && pop) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    // Control state, pointers and count; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            mem_req_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            mem_req_reg <= mem_req_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Memory-side payload registers, held stable until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_reg  <= '0;
            mem_wmask_reg <= '0;
            mem_wdata_reg <= '0;
        end else if (load) begin
            mem_addr_reg  <= load_entry[ADDR_LO +: ADDR_WIDTH];
            mem_wmask_reg <= load_entry[MASK_LO +: Mask_Width];
            mem_wdata_reg <= load_entry[DATA_LO +: DATA_WIDTH];
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wmask = mem_wmask_reg;
    assign mem_wdata = mem_wdata_reg;
    assign buf_count = count_reg;
    assign buf_empty = (count_reg == '0) && !mem_req_reg;

`ifdef STORE_FWD_EN
    logic [DEPTH-1:0]   fwd_match;     // indexed by age, 0 = oldest (head)
    logic [ENTRY_W-1:0] age_entry [DEPTH];
    logic [ADDR_WIDTH-1:0] fwd_word;

    assign fwd_word = fwd_addr & WORD_MASK;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            localparam logic [PTR_WIDTH:0] AGE = gi;
            logic [PTR_WIDTH-1:0] slot;
            assign slot          = rd_ptr_reg + AGE[PTR_WIDTH-1:0];
            assign age_entry[gi] = all_entries[slot];
            assign fwd_match[gi] = (AGE < count_reg) &&
                                   (age_entry[gi][ADDR_LO +: ADDR_WIDTH] == fwd_word);
        end
    endgenerate

    // Byte merge from oldest to youngest so younger stores overwrite the
    // lanes they cover and older ones fill in the rest.
    always_comb begin
        fwd_data = '0;
        fwd_mask = '0;
        if (fwd_check) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (fwd_match[k]) begin
                    for (int b = 0; b < Mask_Width; b++) begin
                        if (age_entry[k][MASK_LO + b]) begin
                            fwd_mask[b]         = 1'b1;
                            fwd_data[b*8 +: 8]  = age_entry[k][DATA_LO + b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    assign fwd_hit = fwd_check && (|fwd_match);
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: reset, single store with delayed ack,
// fill/backpressure, streaming, zero-mask store, mid-run reset and (when
// STORE_FWD_EN is defined) store-to-load forwarding.
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dcache_write;
    logic [3:0]  dcache_mask;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_data;
    logic        dcache_write_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        buf_empty;
    logic [2:0]  buf_count;
`ifdef STORE_FWD_EN
    logic        fwd_check;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_write_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .dcache_write       (dcache_write),
        .dcache_mask        (dcache_mask),
        .dcache_addr        (dcache_addr),
        .dcache_data        (dcache_data),
        .dcache_write_valid (dcache_write_valid),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_wmask          (mem_wmask),
        .mem_wdata          (mem_wdata),
        .mem_ack            (mem_ack),
        .buf_empty          (buf_empty),
        .buf_count          (buf_count)
`ifdef STORE_FWD_EN
        ,
        .fwd_check          (fwd_check),
        .fwd_addr           (fwd_addr),
        .fwd_hit            (fwd_hit),
        .fwd_data           (fwd_data),
        .fwd_mask           (fwd_mask)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; dcache_write = 1'b0; dcache_mask = '0; dcache_addr = '0;
        dcache_data = '0; mem_ack = 1'b0;
`ifdef STORE_FWD_EN
        fwd_check = 1'b0; fwd_addr = '0;
`endif
        #2;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", buf_count); end
        n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", buf_empty); end
        n_cmp++; if (dcache_write_valid !== 1'b1) begin n_err++; $display("FAIL reset_valid: got %b want 1", dcache_write_valid); end
        n_cmp++; if ({mem_addr, mem_wmask, mem_wdata} !== 68'd0) begin n_err++; $display("FAIL reset_payload: got %h/%h/%h want 0", mem_addr, mem_wmask, mem_wdata); end
        tick; tick;
        rst = 1'b1;
        tick;
        $display("reset: req=%b count=%0d empty=%b", mem_req, buf_count, buf_empty);
    endtask

    task automatic test_single_store;
        dcache_write = 1'b1; dcache_addr = 32'h104; dcache_mask = 4'b0011; dcache_data = 32'h0000BEEF;
        tick;
        dcache_write = 1'b0;
        n_cmp++; if (buf_count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", buf_count); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL single_req_early: got %b want 0", mem_req); end
        for (int c = 1; c <= 3; c++) begin
            tick;
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_wmask !== 4'b0011 || mem_wdata !== 32'h0000BEEF) begin
                n_err++;
                $display("FAIL single_hold_c%0d: got req=%b addr=%h mask=%b data=%h want 1/104/0011/0000beef",
                         c, mem_req, mem_addr, mem_wmask, mem_wdata);
            end
            $display("single: cycle %0d req=%b addr=%h mask=%b data=%h", c, mem_req, mem_addr, mem_wmask, mem_wdata);
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        n_cmp++; if (buf_empty !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL single_after_ack: got empty=%b req=%b want 1/0", buf_empty, mem_req); end
        n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL single_count_after: got %0d want 0", buf_count); end
    endtask

    task automatic test_fill;
        logic [31:0] exp_addr;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dcache_write = 1'b1; dcache_addr = 32'h40 + 32'(4 * i); dcache_mask = 4'hF; dcache_data = 32'hA0 + 32'(i);
            tick;
        end
        n_cmp++; if (dcache_write_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid_full: got %b want 0", dcache_write_valid); end
        n_cmp++; if (buf_count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d want 4", buf_count); end
        dcache_addr = 32'h50; dcache_data = 32'hDEAD;
        tick;
        dcache_write = 1'b0;
        n_cmp++; if (buf_count !== 3'd4) begin n_err++; $display("FAIL fill_fifth_rejected: got count %0d want 4", buf_count); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL fill_head: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        n_cmp++; if (dcache_write_valid !== 1'b1 || buf_count !== 3'd3) begin n_err++; $display("FAIL fill_after_ack: got valid=%b count=%0d want 1/3", dcache_write_valid, buf_count); end
        n_cmp++; if (mem_addr !== 32'h44 || mem_wdata !== 32'hA1) begin n_err++; $display("FAIL fill_next_head: got addr=%h data=%h want 44/a1", mem_addr, mem_wdata); end
        $display("fill: full reached, after one ack count=%0d addr=%h", buf_count, mem_addr);
        mem_ack = 1'b1;
        for (int i = 2; i < 4; i++) begin
            tick;
            exp_addr = 32'h40 + 32'(4 * i);
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin n_err++; $display("FAIL fill_drain_%0d: got req=%b addr=%h want 1/%h", i, mem_req, mem_addr, exp_addr); end
        end
        tick;
        mem_ack = 1'b0;
        n_cmp++; if (buf_empty !== 1'b1 || buf_count !== 3'd0) begin n_err++; $display("FAIL fill_drained: got empty=%b count=%0d want 1/0", buf_empty, buf_count); end
    endtask

    task automatic test_streaming;
        logic [31:0] exp_addr;
        mem_ack = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) begin
                dcache_write = 1'b1; dcache_addr = 32'(4 * k); dcache_mask = 4'hF; dcache_data = 32'h100 + 32'(k);
            end else begin
                dcache_write = 1'b0;
            end
            tick;
            if (k >= 1) begin
                exp_addr = 32'(4 * (k - 1));
                n_cmp++;
                if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== 32'h100 + 32'(k - 1)) begin
                    n_err++;
                    $display("FAIL stream_%0d: got req=%b addr=%h data=%h want 1/%h/%h", k, mem_req, mem_addr, mem_wdata, exp_addr, 32'h100 + 32'(k - 1));
                end
                $display("stream: cycle %0d req=%b addr=%h", k, mem_req, mem_addr);
            end
        end
        dcache_write = 1'b0;
        tick;
        mem_ack = 1'b0;
        n_cmp++; if (buf_empty !== 1'b1 || mem_req !== 1'b0) begin n_err++; $display("FAIL stream_end: got empty=%b req=%b want 1/0", buf_empty, mem_req); end
    endtask

    task automatic test_zero_mask;
        dcache_write = 1'b1; dcache_addr = 32'h80; dcache_mask = 4'b0000; dcache_data = 32'h12345678;
        tick;
        dcache_write = 1'b0;
        n_cmp++; if (buf_count !== 3'd0) begin n_err++; $display("FAIL zero_mask_count: got %0d want 0", buf_count); end
        tick;
        n_cmp++; if (mem_req !== 1'b0 || buf_empty !== 1'b1) begin n_err++; $display("FAIL zero_mask_req: got req=%b empty=%b want 0/1", mem_req, buf_empty); end
        $display("zero_mask: count=%0d req=%b", buf_count, mem_req);
    endtask

    task automatic test_reset_mid;
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dcache_write = 1'b1; dcache_addr = 32'h200 + 32'(4 * i); dcache_mask = 4'hF; dcache_data = 32'(i);
            tick;
        end
        dcache_write = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || buf_count !== 3'd3) begin n_err++; $display("FAIL rstmid_pre: got req=%b count=%0d want 1/3", mem_req, buf_count); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || buf_count !== 3'd0) begin n_err++; $display("FAIL rstmid_async: got req=%b count=%0d want 0/0", mem_req, buf_count); end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick;
            n_cmp++; if (mem_req !== 1'b0 || buf_empty !== 1'b1) begin n_err++; $display("FAIL rstmid_stale_%0d: got req=%b empty=%b want 0/1", c, mem_req, buf_empty); end
        end
        $display("reset_mid: req=%b count=%0d", mem_req, buf_count);
    endtask

`ifdef STORE_FWD_EN
    task automatic test_forwarding;
        mem_ack = 1'b0;
        dcache_write = 1'b1; dcache_addr = 32'h24; dcache_mask = 4'hF; dcache_data = 32'hFFFFFFFF;
        tick;
        dcache_addr = 32'h20; dcache_mask = 4'b0001; dcache_data = 32'h11;
        tick;
        dcache_addr = 32'h20; dcache_mask = 4'b0010; dcache_data = 32'h2200;
        tick;
        dcache_write = 1'b0;
        fwd_check = 1'b1; fwd_addr = 32'h23;
        #1;
        n_cmp++;
        if (fwd_hit !== 1'b1 || fwd_mask !== 4'b0011 || fwd_data !== 32'h00002211) begin
            n_err++;
            $display("FAIL fwd_merge: got hit=%b mask=%b data=%h want 1/0011/00002211", fwd_hit, fwd_mask, fwd_data);
        end
        $display("fwd: addr=%h hit=%b mask=%b data=%h", fwd_addr, fwd_hit, fwd_mask, fwd_data);
        fwd_addr = 32'h30;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0 || fwd_mask !== 4'd0) begin n_err++; $display("FAIL fwd_miss: got hit=%b mask=%b want 0/0000", fwd_hit, fwd_mask); end
        // In-flight head (0x24) must still be visible.
        fwd_addr = 32'h24;
        #1;
        n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL fwd_inflight: got hit=%b data=%h want 1/ffffffff", fwd_hit, fwd_data); end
        fwd_check = 1'b0;
        #1;
        n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin n_err++; $display("FAIL fwd_off: got hit=%b data=%h want 0/0", fwd_hit, fwd_data); end
        // Younger store overrides byte 0.
        dcache_write = 1'b1; dcache_addr = 32'h21; dcache_mask = 4'b0001; dcache_data = 32'h55;
        tick;
        dcache_write = 1'b0;
        fwd_check = 1'b1; fwd_addr = 32'h20;
        #1;
        n_cmp++; if (fwd_data !== 32'h00002255 || fwd_mask !== 4'b0011) begin n_err++; $display("FAIL fwd_youngest: got mask=%b data=%h want 0011/00002255", fwd_mask, fwd_data); end
        fwd_check = 1'b0;
        mem_ack = 1'b1;
        for (int c = 0; c < 5; c++) tick;
        mem_ack = 1'b0;
        n_cmp++; if (buf_empty !== 1'b1) begin n_err++; $display("FAIL fwd_drain: got empty=%b want 1", buf_empty); end
    endtask
`endif

    initial begin
        test_reset;
        test_single_store;
        test_fill;
        test_streaming;
        test_zero_mask;
        test_reset_mid;
`ifdef STORE_FWD_EN
        test_forwarding;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
